fu_sequencer: RTL
=================

FU_SEQUENCER -- requirements
Module: fu_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: instr_valid  in  1  instruction offered.
REQ-004 SHALL have ports: instr_ready  out  1  sequencer can accept.
REQ-005 SHALL have ports: instr  in  16  instruction word, with fields:
- FS[15:12]
- DA[11:9]
- AA[8:6]
- BA[5:3]
- MB[2] (1 = OpB is zero-extended BA constant)
- RW[1] (1 = write back)
- bit0 reserved, ignored.
REQ-006 SHALL have ports:
- fu_fs  out  4  function select to function unit.
- fu_opa  out  16  operand A.
- fu_opb  out  16  operand B.
REQ-007 SHALL have ports:
- fu_result  in  16  function unit result.
- fu_v, fu_c, fu_n, fu_z  in  1 each  function unit status.
REQ-008 SHALL have ports: status  out  4  registered {V,C,N,Z}.
REQ-009 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: err  out  1  one-cycle illegal-FS pulse, coincident with done.
REQ-011 SHALL have ports: rd_addr  in  3 and rd_data  out  16, a combinational debug read port.

Function
REQ-012 SHALL hold 8x16 registers R0..R7; R0 reads 0 always and writes to R0 are discarded.
REQ-013 SHALL implement states IDLE, READ, EXEC, WB with these transitions:
- IDLE->READ on instr_valid&&instr_ready
- READ->EXEC
- EXEC->WB
- WB->IDLE
REQ-014 SHALL drive instr_ready=1 only in IDLE with rst low; instr is sampled and latched only on the accept edge.
REQ-015 SHALL, in READ, latch fu_opa<=R[AA] and fu_opb<=(MB ? {13'b0,BA} : R[BA]), and latch fu_fs<=FS.
REQ-016 SHALL hold fu_fs/fu_opa/fu_opb stable from end of READ until the next READ; the function unit is combinational, and its outputs are sampled at the end of EXEC.
REQ-017 SHALL treat FS 0100, 0110, 1111 as illegal: no register write, status unchanged, done=1 and err=1 in WB.
REQ-018 SHALL, for legal FS in WB, write the sampled result to R[DA] if RW=1 (subject to REQ-012), and load status with the sampled {V,C,N,Z} regardless of RW.
REQ-019 SHALL assert done for exactly one cycle in WB; accept-to-done latency is 3 cycles, and the next accept is possible 1 cycle after done.
REQ-020 SHALL return the pre-write value on rd_data when rd_addr==DA during the WB cycle; the new value is visible the following cycle.
REQ-021 SHALL ignore instr_valid outside IDLE; a request held high is accepted on the next IDLE cycle.

Reset
REQ-022 SHALL, on rst high at a clock edge, clear:
- state->IDLE
- R1..R7=0
- fu_fs=0, fu_opa=0, fu_opb=0
- status=0, done=0, err=0
REQ-023 SHALL abort any in-flight instruction on reset in any state, with no write-back and no done.
REQ-024 SHALL force instr_ready=0 while rst is high.

Structure
REQ-025 SHALL place the state encoding, FS legal/illegal constants and instr field positions in shared package fu_seq_pkg.
REQ-026 SHALL implement the register file as sub-module reg_file_8x16: 1 write port, 3 combinational read ports (A, B, debug), and R0 hardwired to zero.
REQ-027 SHALL instantiate no function unit internally; the function unit connects externally via fu_* ports.

Verification
REQ-028 SHALL cover the ADD immediate case:
- stimulus: FS=0000, DA=1, AA=0, MB=1, BA=5, RW=1
- response: done 3 cycles after accept, R1=0x0005, status Z=0, N=0.
REQ-029 SHALL cover the SUB-to-zero case:
- stimulus: after REQ-028, FS=0001, DA=2, AA=1, MB=1, BA=5, RW=1
- response: R2=0x0000, status Z=1, C=1, V=0.
REQ-030 SHALL cover the illegal-FS case:
- stimulus: FS=0110, RW=1, DA=3
- response: done=1 and err=1 same cycle, R3 unchanged, status unchanged.
REQ-031 SHALL cover the R0-write case:
- stimulus: FS=0000, DA=0, MB=1, BA=7, RW=1
- response: rd_addr=0 reads 0x0000 afterward, status updated (Z=0).
REQ-032 SHALL cover reset during EXEC:
- stimulus: rst pulsed during EXEC of a RW=1 instruction
- response: no done, destination register 0, instr_ready=1 the cycle after rst falls.
REQ-033 SHALL cover a held request:
- stimulus: instr_valid held high across two instructions
- response: second accepted exactly the cycle after the first done, instr_ready low throughout READ/EXEC/WB.

Source files
------------

// File: rtl/fu_seq_pkg.sv
// Shared definitions for the function-unit sequencer: state encoding,
// instruction field positions and the set of illegal function selects.
package fu_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam int FS_HI  = 15;
  localparam int FS_LO  = 12;
  localparam int DA_HI  = 11;
  localparam int DA_LO  = 9;
  localparam int AA_HI  = 8;
  localparam int AA_LO  = 6;
  localparam int BA_HI  = 5;
  localparam int BA_LO  = 3;
  localparam int MB_BIT = 2;
  localparam int RW_BIT = 1;

  localparam logic [3:0] FS_ILLEGAL_A = 4'b0100;
  localparam logic [3:0] FS_ILLEGAL_B = 4'b0110;
  localparam logic [3:0] FS_ILLEGAL_C = 4'b1111;

  function automatic logic fs_is_illegal(input logic [3:0] fs);
    return (fs == FS_ILLEGAL_A) || (fs == FS_ILLEGAL_B) || (fs == FS_ILLEGAL_C);
  endfunction

endpackage

// File: rtl/fu_sequencer_reg_file.sv
// 8x16 register file: one write port, three combinational read ports.
// R0 is never written, so it always reads zero.
module reg_file_8x16
  import fu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [2:0]  ra_addr,
  input  logic [2:0]  rb_addr,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] ra_data,
  output logic [15:0] rb_data,
  output logic [15:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Next register contents: apply the write, then pin R0 back to zero.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = '0;
  end

  // Storage flops, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/fu_sequencer.sv
// Four-phase sequencer (IDLE/READ/EXEC/WB) that feeds an external
// combinational function unit from a local register file and writes back.
module fu_sequencer
  import fu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  fu_fs,
  output logic [15:0] fu_opa,
  output logic [15:0] fu_opb,
  input  logic [15:0] fu_result,
  input  logic        fu_v,
  input  logic        fu_c,
  input  logic        fu_n,
  input  logic        fu_z,
  output logic [3:0]  status,
  output logic        done,
  output logic        err,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data
);

  state_e       state_q, state_d;
  logic [15:1]  instr_q, instr_d;
  logic [3:0]   fu_fs_q, fu_fs_d;
  logic [15:0]  fu_opa_q, fu_opa_d;
  logic [15:0]  fu_opb_q, fu_opb_d;
  logic [15:0]  result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic [3:0]   status_q, status_d;

  logic [15:0]  ra_data, rb_data;
  logic         illegal;
  logic         wr_en;
  logic         unused_bit0;

  assign unused_bit0 = instr[0];
  assign illegal     = fs_is_illegal(instr_q[FS_HI:FS_LO]);
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign done        = (state_q == S_WB) && !rst;
  assign err         = done && illegal;
  assign wr_en       = done && !illegal && instr_q[RW_BIT];

  reg_file_8x16 u_regs (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_en),
    .wr_addr  (instr_q[DA_HI:DA_LO]),
    .wr_data  (result_q),
    .ra_addr  (instr_q[AA_HI:AA_LO]),
    .rb_addr  (instr_q[BA_HI:BA_LO]),
    .dbg_addr (rd_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (rd_data)
  );

  // Phase sequencing: latch instruction, operands, FU result and status.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    fu_fs_d  = fu_fs_q;
    fu_opa_d = fu_opa_q;
    fu_opb_d = fu_opb_q;
    result_d = result_q;
    flags_d  = flags_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          instr_d = instr[15:1];
          state_d = S_READ;
        end
      end
      S_READ: begin
        fu_fs_d  = instr_q[FS_HI:FS_LO];
        fu_opa_d = ra_data;
        fu_opb_d = instr_q[MB_BIT] ? {13'b0, instr_q[BA_HI:BA_LO]} : rb_data;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d = fu_result;
        flags_d  = {fu_v, fu_c, fu_n, fu_z};
        state_d  = S_WB;
      end
      S_WB: begin
        if (!illegal) begin
          status_d = flags_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      fu_fs_q  <= '0;
      fu_opa_q <= '0;
      fu_opb_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      fu_fs_q  <= fu_fs_d;
      fu_opa_q <= fu_opa_d;
      fu_opb_q <= fu_opb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      status_q <= status_d;
    end
  end

  assign fu_fs  = fu_fs_q;
  assign fu_opa = fu_opa_q;
  assign fu_opb = fu_opb_q;
  assign status = status_q;

endmodule
